ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 7 +
 rtl/rr_grant.sv | 26 ++
 rtl/ram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM port arbiter: default geometry and statistics counter width.
package ram_arb_pkg;
    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 6;
    localparam int DW_DEF   = 8;
    localparam int CNT_W    = 16;
endpackage

// File: rtl/rr_grant.sv
// Round-robin selector: one-hot grant to the first valid requester at or after ptr, wrapping.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);
    logic          found;
    logic [IW-1:0] idx;

    // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NREQ requesters, fixed 2-cycle response latency.
// Optional build macro RAM_ARB_STATS_EN adds per-requester saturating grant counters on grant_cnt.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_we,
    input  logic [NREQ*AW-1:0]            req_addr,
    input  logic [NREQ*DW-1:0]            req_wdata,
    output logic [NREQ-1:0]               req_ready,
    output logic [AW-1:0]                 ram_addr,
    output logic [DW-1:0]                 ram_data,
    output logic                          ram_we,
    input  logic [DW-1:0]                 ram_q,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [DW-1:0]                 rsp_data
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]         grant_cnt
`endif
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   ptr_next;
    logic [NREQ-1:0] grant;
    logic            accept;

    logic            s1_valid, s1_we;
    logic [IW-1:0]   s1_id;
    logic            s2_valid, s2_we;
    logic [IW-1:0]   s2_id;
    logic [DW-1:0]   s2_data;

    rr_grant #(.N(NREQ), .IW(IW)) u_rr_grant (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Grants are suppressed while reset is held so nothing is accepted during reset.
    assign req_ready = rst ? '0 : grant;
    assign accept    = |req_ready;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
        ptr_next = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_we     <= 1'b0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_we     <= 1'b0;
            s2_id     <= '0;
            s2_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            ram_we   <= accept & req_we[gidx];
            s1_valid <= accept;
            s1_id    <= gidx;
            s1_we    <= req_we[gidx];
            if (accept) begin
                ptr      <= ptr_next;
                ram_addr <= req_addr[int'(gidx)*AW +: AW];
                ram_data <= req_wdata[int'(gidx)*DW +: DW];
            end
            // ram_q becomes valid the cycle after the RAM samples ram_addr, i.e. alongside stage 2.
            s2_valid  <= s1_valid;
            s2_id     <= s1_id;
            s2_we     <= s1_we;
            s2_data   <= ram_data;
            rsp_valid <= s2_valid;
            if (s2_valid) begin
                rsp_id   <= s2_id;
                rsp_data <= s2_we ? s2_data : ram_q;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [NREQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`else
    // Statistics disabled: no grant counters are built.
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_ram_port_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 6;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_data;
    logic                 ram_we;
    logic [DW-1:0]        ram_q;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [DW-1:0]        rsp_data;
`ifdef RAM_ARB_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt;
`endif

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef RAM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM attached to the arbiter's port.
    logic [DW-1:0] mem [64] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Reference model state.
    typedef struct {
        int           due;
        int           id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [64];
    int            ptr_m;
    int            cyc;
    int            cnt_m [NREQ];
    bit            lw_v;
    int            lw_addr;
    logic [DW-1:0] lw_old;
    int            vectors;
    int            miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input int a, input int d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = DW'(d);
    endtask

    task automatic rand_req(input int i, input bit v);
        set_req(i, v, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255));
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, 0);
    endtask

    // One clock cycle from a falling edge: check grant, apply the model at the rising edge, check outputs.
    task automatic cycle();
        int            g;
        int            a;
        logic [DW-1:0] d;
        bit            we;
        bit            exp_we;
        logic [3:0]    exp_ready;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        exp_ready = (g < 0) ? 4'b0000 : (4'b0001 << g);
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        cyc++;
        lw_v   = 1'b0;
        exp_we = 1'b0;
        if (g >= 0) begin
            a  = int'(req_addr[g*AW +: AW]);
            d  = req_wdata[g*DW +: DW];
            we = req_we[g];
            if (we) begin
                lw_v       = 1'b1;
                lw_addr    = a;
                lw_old     = ref_mem[a];
                ref_mem[a] = d;
                exp_we     = 1'b1;
            end
            exp_q.push_back('{due: cyc + 2, id: g, data: ref_mem[a]});
            ptr_m = (g + 1) % NREQ;
            if (cnt_m[g] < 16'hFFFF) cnt_m[g]++;
        end
        #1;
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
    endtask

    // Assert reset from a falling edge for n rising edges; in-flight work is discarded.
    task automatic do_reset(input int n);
        idle_inputs();
        rst = 1'b1;
        if (lw_v) ref_mem[lw_addr] = lw_old;
        lw_v  = 1'b0;
        exp_q.delete();
        ptr_m = 0;
        for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
        #1;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_hold_ram_we", 32'(ram_we), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        ptr_m       = 0;
        lw_v        = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;

        // Reset values with every requester asking.
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        chk("reset_ram_data", 32'(ram_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All requesters valid continuously from reset: grants rotate 0,1,2,3,0,...
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
            cycle();
        end

        // Idle: pipeline drains, then three quiet cycles with the pointer held.
        idle_inputs();
        repeat (5) cycle();
        for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
        cycle();
        idle_inputs();
        repeat (2) cycle();

        // Write 0xA5 to 0x3F by req0, then read it back by req1 in the next cycle.
        set_req(0, 1'b1, 1'b1, 'h3F, 'hA5);
        cycle();
        idle_inputs();
        set_req(1, 1'b1, 1'b0, 'h3F, 'h00);
        cycle();
        idle_inputs();
        repeat (2) cycle();

        // A lone requester is served every cycle regardless of pointer position.
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            rand_req(2, 1'b1);
            cycle();
        end
        idle_inputs();
        repeat (2) cycle();

        // Reset half a cycle after a write to 0x10 is accepted: the write and its response vanish.
        set_req(1, 1'b1, 1'b1, 'h10, 'h33);
        cycle();
        idle_inputs();
        repeat (2) cycle();
        set_req(0, 1'b1, 1'b1, 'h10, 'h5A);
        cycle();
        do_reset(2);
        repeat (2) cycle();
        for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
        cycle();
        idle_inputs();
        set_req(3, 1'b1, 1'b0, 'h10, 'h00);
        cycle();
        idle_inputs();
        repeat (2) cycle();

        // Randomized traffic.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) rand_req(i, 1'($urandom_range(0, 1)));
            cycle();
        end
        idle_inputs();
        repeat (2) cycle();

`ifdef RAM_ARB_STATS_EN
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            rand_req(3, 1'b1);
            cycle();
        end
        idle_inputs();
        repeat (2) cycle();
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("grant_cnt%0d", i), 32'(grant_cnt[i*16 +: 16]), 32'(cnt_m[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
